fetch_unit: RTL

- Instruction-fetch stage directly downstream of the PC-source decision logic.
- Consumes the 2-bit PC-source code and both redirect targets, owns the PC register, and drives a synchronous-read instruction memory (1-cycle read latency).
- Fills the IF/ID pipeline register, including PC+4 for CALL link.
- Kills wrong-path fetches on a taken J/CALL/JR.

---
 rtl/fetch_unit_pkg.sv | 15 +
 rtl/fetch_next_pc.sv | 33 +++
 rtl/fetch_unit.sv | 84 ++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants: PC-source codes (also used by the PC-source
// control block), default bubble encoding and the sequential PC increment.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ  = 2'b00,
    PCSRC_JUMP = 2'b01,
    PCSRC_JR   = 2'b10,
    PCSRC_RSVD = 2'b11
  } pcsrc_e;

  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
  localparam int unsigned PC_INC       = 4;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection for the fetch stage: sequential, J/CALL target, or
// word-aligned JR target. Also flags whether the selection is a redirect.
module fetch_next_pc
  import fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [1:0]          pc_src,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic [PC_WIDTH-1:0] jr_target,
  output logic [PC_WIDTH-1:0] next_pc,
  output logic                taken
);

  always_comb begin
    next_pc = pc + PC_WIDTH'(PC_INC);
    taken   = 1'b0;
    case (pc_src)
      PCSRC_JUMP: begin
        next_pc = jump_target;
        taken   = 1'b1;
      end
      PCSRC_JR: begin
        // Low two bits of a register target are dropped, not trapped.
        next_pc = jr_target & ~PC_WIDTH'(3);
        taken   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle synchronous imem,
// fills IF/ID and kills the two wrong-path slots behind a taken redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                    PC_WIDTH   = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = INST_WIDTH'(NOP_INST_DEF),
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            pc_src,
  input  logic [PC_WIDTH-1:0]   jump_target,
  input  logic [PC_WIDTH-1:0]   jr_target,
  input  logic                  stall,
  output logic [PC_WIDTH-1:0]   imem_addr,
  output logic                  imem_en,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic [INST_WIDTH-1:0] if_id_inst,
  output logic [PC_WIDTH-1:0]   if_id_pc,
  output logic [PC_WIDTH-1:0]   if_id_pc_plus4,
  output logic                  if_id_valid,
  output logic [CNT_WIDTH-1:0]  redirect_count
);

  logic [PC_WIDTH-1:0] pc_p0;
  logic [PC_WIDTH-1:0] req_pc_p1;
  logic                vld_p1;
  logic [PC_WIDTH-1:0] next_pc;
  logic                taken;
  logic                redirect;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  fetch_next_pc #(
    .PC_WIDTH (PC_WIDTH)
  ) u_next_pc (
    .pc          (pc_p0),
    .pc_src      (pc_src),
    .jump_target (jump_target),
    .jr_target   (jr_target),
    .next_pc     (next_pc),
    .taken       (taken)
  );

  // Stall outranks any redirect request.
  assign redirect  = taken & ~stall;
  assign imem_addr = pc_p0;
  assign imem_en   = ~stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_p0          <= RESET_PC;
      req_pc_p1      <= RESET_PC;
      vld_p1         <= 1'b0;
      if_id_inst     <= NOP_INST;
      if_id_pc       <= '0;
      if_id_pc_plus4 <= '0;
      if_id_valid    <= 1'b0;
      redirect_count <= '0;
    end else if (!stall) begin
      // p0 -> p1: issue fetch at pc_p0; a redirect kills it
      pc_p0     <= next_pc;
      req_pc_p1 <= pc_p0;
      vld_p1    <= ~redirect;
      // p1 -> IF/ID: capture returning data, killed or bubble slots become NOP
      if_id_pc       <= req_pc_p1;
      if_id_pc_plus4 <= req_pc_p1 + PC_WIDTH'(PC_INC);
      if (redirect || !vld_p1) begin
        if_id_inst  <= NOP_INST;
        if_id_valid <= 1'b0;
      end else begin
        if_id_inst  <= imem_rdata;
        if_id_valid <= 1'b1;
      end
      if (redirect) redirect_count <= sat_inc(redirect_count);
    end
  end

endmodule
